// File: rtl/vec_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module : vec_issue_pkg
// Brief  : Shared types and defaults for the vector issue sequencer.
// Rev    : 1.0
// ============================================================================
package vec_issue_pkg;

  localparam int c_XLEN            = 32;
  localparam int c_DEPTH_DEFAULT   = 4;
  localparam int c_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_XLEN-1:0] inst;
    logic [c_XLEN-1:0] rs1;
    logic [c_XLEN-1:0] rs2;
  } vec_entry_t;

endpackage
`default_nettype wire

// File: rtl/vec_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module : vec_inst_fifo
// Brief  : Power-of-two instruction queue with wrap-around pointers.
// Rev    : 1.0
// ============================================================================
module vec_inst_fifo
  import vec_issue_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  vec_entry_t             push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output vec_entry_t             head
);

  localparam int c_AW = $clog2(DEPTH);

  vec_entry_t        r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == (c_AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : vec_issue_sequencer
// Brief  : Queues scalar-side vector instructions and issues them one at a time.
// Rev    : 1.0
// ============================================================================
module vec_issue_sequencer
  import vec_issue_pkg::*;
#(
  parameter int DEPTH   = c_DEPTH_DEFAULT,
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_valid,
  input  logic [c_XLEN-1:0]      inst_in,
  input  logic [c_XLEN-1:0]      rs1_in,
  input  logic [c_XLEN-1:0]      rs2_in,
  output logic                   inst_ready,
  output logic                   issue_valid,
  output logic [c_XLEN-1:0]      issue_inst,
  output logic [c_XLEN-1:0]      issue_rs1,
  output logic [c_XLEN-1:0]      issue_rs2,
  input  logic                   is_vec,
  input  logic                   inst_done,
  output logic                   vec_pro_ack,
  output logic                   resp_err,
  input  logic                   scalar_pro_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int               c_WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_WDW-1:0]  r_wd;
  logic [c_WDW-1:0]  w_wd_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  vec_entry_t        w_push_data;
  vec_entry_t        w_head;

  assign w_push_data = '{inst: inst_in, rs1: rs1_in, rs2: rs2_in};

  vec_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inst_valid),
    .push_data (w_push_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (occupancy),
    .head      (w_head)
  );

  assign inst_ready = !w_full;
  assign issue_inst = w_head.inst;
  assign issue_rs1  = w_head.rs1;
  assign issue_rs2  = w_head.rs2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_err_nxt   = r_err;
    w_pop       = 1'b0;
    issue_valid = 1'b0;
    vec_pro_ack = 1'b0;
    resp_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (is_vec) begin
          w_wd_nxt    = '0;
          w_state_nxt = BUSY;
        end else begin
          w_pop       = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      BUSY: begin
        issue_valid = 1'b1;
        w_wd_nxt    = r_wd + 1'b1;
        // Completion wins over an expiring watchdog in the same cycle.
        if (inst_done) begin
          w_pop       = 1'b1;
          w_err_nxt   = 1'b0;
          w_state_nxt = RESP;
        end else if (r_wd == c_WD_LAST) begin
          w_pop       = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        vec_pro_ack = 1'b1;
        resp_err    = r_err;
        if (scalar_pro_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_vec_issue_sequencer
// Brief  : Randomized bench against a transaction-level issue/response model.
// Rev    : 1.0
// ============================================================================
module tb_vec_issue_sequencer;
  import vec_issue_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 8;
  localparam int OW       = $clog2(DEPTH) + 1;
  localparam int N_CYCLES = 6000;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_valid;
  logic [c_XLEN-1:0] inst_in;
  logic [c_XLEN-1:0] rs1_in;
  logic [c_XLEN-1:0] rs2_in;
  logic              inst_ready;
  logic              issue_valid;
  logic [c_XLEN-1:0] issue_inst;
  logic [c_XLEN-1:0] issue_rs1;
  logic [c_XLEN-1:0] issue_rs2;
  logic              is_vec;
  logic              inst_done;
  logic              vec_pro_ack;
  logic              resp_err;
  logic              scalar_pro_ready;
  logic [OW-1:0]     occupancy;

  always #5 clk = ~clk;

  vec_issue_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_valid       (inst_valid),
    .inst_in          (inst_in),
    .rs1_in           (rs1_in),
    .rs2_in           (rs2_in),
    .inst_ready       (inst_ready),
    .issue_valid      (issue_valid),
    .issue_inst       (issue_inst),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .is_vec           (is_vec),
    .inst_done        (inst_done),
    .vec_pro_ack      (vec_pro_ack),
    .resp_err         (resp_err),
    .scalar_pro_ready (scalar_pro_ready),
    .occupancy        (occupancy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the queue contents plus, for the instruction in flight,
  // how many cycles its issue window lasts and what its response will be.
  typedef struct {
    logic [c_XLEN-1:0] inst;
    logic [c_XLEN-1:0] rs1;
    logic [c_XLEN-1:0] rs2;
  } ref_entry_t;

  typedef enum int {M_WAIT, M_WIN, M_ACK} mphase_t;

  ref_entry_t mq[$];
  ref_entry_t e;
  mphase_t    ph;
  int         pos;
  int         win_len;
  int         k;
  int         r;
  int         seg;
  int         vp;
  int         stall;
  int         n_resets;
  bit         legal;
  bit         m_err;
  bit         first_push;
  bit         just_reset;
  bit         do_reset;
  bit         acc;
  bit         had;

  task automatic plan_instruction();
    legal = ($urandom_range(0, 4) != 0);
    r     = $urandom_range(0, 99);
    if (r < 20)      k = 0;
    else if (r < 35) k = TIMEOUT;
    else             k = $urandom_range(1, TIMEOUT - 1);
    win_len = !legal ? 1 : 1 + ((k == 0) ? TIMEOUT : k);
    m_err   = !legal || (k == 0);
  endtask

  initial begin
    ph         = M_WAIT;
    pos        = 0;
    win_len    = 0;
    k          = 0;
    stall      = 0;
    n_resets   = 0;
    legal      = 1'b1;
    m_err      = 1'b0;
    first_push = 1'b1;
    just_reset = 1'b1;
    reset            = 1'b1;
    inst_valid       = 1'b0;
    inst_in          = '0;
    rs1_in           = '0;
    rs2_in           = '0;
    is_vec           = 1'b0;
    inst_done        = 1'b0;
    scalar_pro_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      check("occupancy",   32'(occupancy),   32'(mq.size()));
      check("inst_ready",  32'(inst_ready),  32'(mq.size() != DEPTH));
      check("issue_valid", 32'(issue_valid), 32'(ph == M_WIN));
      check("vec_pro_ack", 32'(vec_pro_ack), 32'(ph == M_ACK));
      if (ph == M_ACK) check("resp_err", 32'(resp_err), 32'(m_err));
      if (just_reset)  check("resp_err_after_reset", 32'(resp_err), 32'd0);
      if (ph == M_WIN) begin
        check("issue_inst", issue_inst, mq[0].inst);
        check("issue_rs1",  issue_rs1,  mq[0].rs1);
        check("issue_rs2",  issue_rs2,  mq[0].rs2);
      end
      just_reset = 1'b0;

      seg      = (cyc / 400) % 4;
      do_reset = 1'b0;
      if (n_resets < 6 && ph == M_WIN && pos >= 2 && mq.size() >= 3 &&
          $urandom_range(0, 3) == 0) do_reset = 1'b1;
      if (n_resets < 6 && ph == M_ACK && $urandom_range(0, 59) == 0) do_reset = 1'b1;
      reset = do_reset;

      vp = (seg == 0) ? 90 : (seg == 1) ? 40 : (seg == 2) ? 95 : 10;
      inst_valid = ($urandom_range(0, 99) < vp);
      inst_in    = first_push ? 32'h0200_8057 : $urandom();
      rs1_in     = $urandom();
      rs2_in     = $urandom();
      is_vec     = (ph == M_WIN && pos == 0) ? legal : 1'($urandom_range(0, 1));
      inst_done  = (ph == M_WIN && pos >= 1) ? (pos == k) : ($urandom_range(0, 7) == 0);
      if (ph == M_ACK && stall > 0) begin
        scalar_pro_ready = 1'b0;
        stall--;
      end else begin
        scalar_pro_ready = ($urandom_range(0, 99) < ((seg == 2) ? 15 : 60));
      end

      if (do_reset) begin
        mq.delete();
        ph         = M_WAIT;
        pos        = 0;
        stall      = 0;
        just_reset = 1'b1;
        n_resets++;
      end else begin
        acc = inst_valid && (mq.size() < DEPTH);
        had = (mq.size() > 0);
        e   = '{inst_in, rs1_in, rs2_in};
        case (ph)
          M_WAIT: begin
            if (had) begin
              ph  = M_WIN;
              pos = 0;
              plan_instruction();
            end
          end
          M_WIN: begin
            pos++;
            if (pos == win_len) begin
              void'(mq.pop_front());
              ph = M_ACK;
              if ($urandom_range(0, 7) == 0) stall = 10;
            end
          end
          default: begin
            if (scalar_pro_ready) ph = M_WAIT;
          end
        endcase
        if (acc) begin
          mq.push_back(e);
          first_push = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
